dm_arbiter: RTL

- Arbitrates the single-port data memory (DM) between two requesters:
  - the pipeline MEM stage, which has priority;
  - a burst loader/debug port that fills or dumps DM blocks.
- Sequences loader bursts with an address counter and a starvation guard.
- Drives the pipeline stall when the loader takes a cycle.
- Sits between the MEM stage and the DM instance.

---
 rtl/dm_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Single-port data memory arbiter. The pipeline MEM stage has
//                priority; a burst loader/debug port fills or dumps DM blocks
//                and is force-granted after MAX_WAIT consecutive denials.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    // pipeline MEM stage
    input  logic [15:0]      p_addr,
    input  logic [15:0]      p_wdata,
    input  logic             p_re,
    input  logic             p_we,
    output logic [15:0]      p_rdata,
    output logic             p_stall,
    // burst loader / debug port
    input  logic             l_start,
    input  logic             l_wr,
    input  logic [15:0]      l_base,
    input  logic [LEN_W-1:0] l_len,
    input  logic [15:0]      l_wdata,
    output logic             l_wack,
    output logic [15:0]      l_rdata,
    output logic             l_rvld,
    output logic             l_busy,
    output logic             l_done,
    // data memory
    output logic [15:0]      dm_addr,
    output logic             dm_re,
    output logic             dm_we,
    output logic [15:0]      dm_wdata,
    input  logic [15:0]      dm_rdata
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [15:0]        addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic               dir_q;
    logic [15:0]        l_rdata_q;
    logic               l_rvld_q;

    logic               w_preq;
    logic               w_lgnt;

    // Loader grant: only while bursting, when the pipeline is quiet or the
    // loader has been starved long enough. Reset suppresses any grant.
    always_comb begin
        w_preq = p_re | p_we;
        w_lgnt = ~rst && (state_q == S_BURST) && (~w_preq || (wait_q == c_max_wait));
    end

    // Starvation counter next value: counts denied burst cycles, saturating.
    always_comb begin
        wait_d = '0;
        if ((state_q == S_BURST) && ~w_lgnt) begin
            wait_d = (wait_q == c_max_wait) ? wait_q : wait_q + WAIT_W'(1);
        end
    end

    // DM mux: loader access when granted, otherwise the pipeline access.
    // Write wins over read for the pipeline; everything quiet under reset.
    always_comb begin
        dm_addr  = w_lgnt ? addr_q  : p_addr;
        dm_wdata = w_lgnt ? l_wdata : p_wdata;
        dm_we    = w_lgnt ? dir_q   : (~rst & p_we);
        dm_re    = w_lgnt ? ~dir_q  : (~rst & p_re & ~p_we);
        p_stall  = w_lgnt & w_preq;
        l_wack   = w_lgnt & dir_q;
        l_busy   = ~rst & (state_q == S_BURST);
        l_done   = ~rst & (state_q == S_DONE);
        p_rdata  = dm_rdata;
        l_rdata  = l_rdata_q;
        l_rvld   = l_rvld_q;
    end

    // Burst sequencer: state, address/length counters and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wait_q    <= '0;
            dir_q     <= 1'b0;
            l_rdata_q <= '0;
            l_rvld_q  <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            l_rvld_q <= w_lgnt & ~dir_q;
            if (w_lgnt && !dir_q) begin
                l_rdata_q <= dm_rdata;
            end
            case (state_q)
                S_IDLE: begin
                    if (l_start) begin
                        if (l_len != '0) begin
                            state_q <= S_BURST;
                            addr_q  <= l_base;
                            rem_q   <= l_len;
                            dir_q   <= l_wr;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_BURST: begin
                    if (w_lgnt) begin
                        addr_q <= addr_q + 16'd1;
                        rem_q  <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
